// File: rtl/axi_err_slv_pkg.sv
// Shared AXI types for the error slave: channel structs, response codes and the R FSM states.
package axi_err_slv_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Bit of aw.atop that marks an atomic which also returns read data.
  localparam int unsigned ATOP_R_RESP = 5;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    resp_t                resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    resp_t                resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } rsp_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_SEND = 2'd1
  } r_state_e;

endpackage

// File: rtl/axi_err_slv_fifo.sv
// Small valid/ready FIFO without fall-through: push when ready_o, pop when valid_o && ready_i.
module axi_err_slv_fifo #(
  parameter int unsigned Depth  = 1,
  parameter type         data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  clr_i,
  input  data_t data_i,
  input  logic  valid_i,
  output logic  ready_o,
  output data_t data_o,
  output logic  valid_o,
  input  logic  ready_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  data_t            mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push, pop;

  // A full FIFO never accepts, even if it is popped in the same cycle.
  assign ready_o = (cnt_q != CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_err_slv.sv
// Terminating AXI4 slave: absorbs every request and answers each burst with a fixed error response.
// Handshake: a beat transfers on a rising clk_i edge where valid && ready; valid never drops without it.
module axi_err_slv
  import axi_err_slv_pkg::*;
#(
  parameter int unsigned           AxiIdWidth = IdWidth,
  parameter type                   axi_req_t  = req_t,
  parameter type                   axi_resp_t = rsp_t,
  parameter resp_t                 Resp       = RESP_DECERR,
  parameter int unsigned           RespWidth  = 64,
  parameter logic [RespWidth-1:0]  RespData   = 64'hCA11AB1EBADCAB1E,
  parameter int unsigned           MaxTrans   = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o
);

  typedef logic [AxiIdWidth-1:0] id_t;
  typedef struct packed {
    id_t        id;
    logic [7:0] len;
  } rcmd_t;

  id_t      wid_head, bid_head;
  rcmd_t    rcmd_in, rcmd_head;
  logic     wid_ready, wid_valid, bid_ready, bid_valid, rcmd_ready, rcmd_valid;
  logic     aw_ready, ar_ready, w_ready;
  logic     aw_hs, atop_push, ar_hs, w_hs, w_last_hs, rcmd_pop;
  logic     r_valid, r_last;
  r_state_e state_q;
  logic [7:0] r_cnt_q;
  logic     unused_bits;

  assign unused_bits = ^slv_req_i;

  // An ATOP_R_RESP atomic needs a read-command slot as well, and takes priority over AR.
  assign aw_ready  = wid_ready && (!slv_req_i.aw.atop[ATOP_R_RESP] || rcmd_ready);
  assign aw_hs     = slv_req_i.aw_valid && aw_ready;
  assign atop_push = aw_hs && slv_req_i.aw.atop[ATOP_R_RESP];
  assign ar_ready  = rcmd_ready && !atop_push;
  assign ar_hs     = slv_req_i.ar_valid && ar_ready;
  assign w_ready   = wid_valid && bid_ready;
  assign w_hs      = slv_req_i.w_valid && w_ready;
  assign w_last_hs = w_hs && slv_req_i.w.last;
  assign r_valid   = (state_q == R_SEND);
  assign r_last    = (r_cnt_q == 8'd0);
  assign rcmd_pop  = r_valid && slv_req_i.r_ready && r_last;

  always_comb begin
    rcmd_in = '0;
    if (atop_push) begin
      rcmd_in.id  = slv_req_i.aw.id;
      rcmd_in.len = slv_req_i.aw.len;
    end else begin
      rcmd_in.id  = slv_req_i.ar.id;
      rcmd_in.len = slv_req_i.ar.len;
    end
  end

  axi_err_slv_fifo #(.Depth(MaxTrans), .data_t(id_t)) i_wid_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (1'b0),
    .data_i  (slv_req_i.aw.id),
    .valid_i (aw_hs),
    .ready_o (wid_ready),
    .data_o  (wid_head),
    .valid_o (wid_valid),
    .ready_i (w_last_hs)
  );

  axi_err_slv_fifo #(.Depth(MaxTrans), .data_t(id_t)) i_bid_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (1'b0),
    .data_i  (wid_head),
    .valid_i (w_last_hs),
    .ready_o (bid_ready),
    .data_o  (bid_head),
    .valid_o (bid_valid),
    .ready_i (slv_req_i.b_ready)
  );

  axi_err_slv_fifo #(.Depth(MaxTrans), .data_t(rcmd_t)) i_rcmd_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (1'b0),
    .data_i  (rcmd_in),
    .valid_i (atop_push || ar_hs),
    .ready_o (rcmd_ready),
    .data_o  (rcmd_head),
    .valid_o (rcmd_valid),
    .ready_i (rcmd_pop)
  );

  // r_cnt_q counts remaining beats after the current one; the burst ends at 0, so no underflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= R_IDLE;
      r_cnt_q <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (rcmd_valid) begin
            r_cnt_q <= rcmd_head.len;
            state_q <= R_SEND;
          end
        end
        R_SEND: begin
          if (slv_req_i.r_ready) begin
            if (r_last) state_q <= R_IDLE;
            else        r_cnt_q <= r_cnt_q - 8'd1;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = bid_valid;
    if (bid_valid) begin
      slv_resp_o.b.id   = bid_head;
      slv_resp_o.b.resp = Resp;
    end
    slv_resp_o.r_valid = r_valid;
    if (r_valid) begin
      slv_resp_o.r.id   = rcmd_head.id;
      slv_resp_o.r.data = RespData[DataWidth-1:0];
      slv_resp_o.r.resp = Resp;
      slv_resp_o.r.last = r_last;
    end
  end

  a_w_after_aw: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_hs |-> wid_valid);
  a_last_is_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_valid && slv_req_i.r_ready && r_last) == rcmd_pop);
  a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_resp_o.r_valid && !slv_req_i.r_ready) |=> (slv_resp_o.r_valid && $stable(slv_resp_o.r)));
  a_b_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_resp_o.b_valid && !slv_req_i.b_ready) |=> (slv_resp_o.b_valid && $stable(slv_resp_o.b)));

endmodule

// File: tb/tb_axi_err_slv.sv
// Bench for axi_err_slv: directed scenarios plus random traffic scored against a queue-based model.
module tb_axi_err_slv;
  import axi_err_slv_pkg::*;

  localparam int unsigned MT   = 2;
  localparam resp_t       RESP = RESP_SLVERR;
  localparam logic [63:0] DATA = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  req_t req;
  rsp_t rsp;

  int tests = 0;
  int fails = 0;

  // Model state: ids awaiting W.last, pending B ids, expected R beats {id, last}, open read commands.
  logic [3:0] wq[$];
  logic [3:0] exp_b_q[$];
  logic [4:0] exp_r_q[$];
  int         rc = 0;
  logic       prev_r_stall = 1'b0, prev_b_stall = 1'b0;
  r_chan_t    prev_r;
  b_chan_t    prev_b;

  axi_err_slv #(
    .AxiIdWidth (4),
    .axi_req_t  (req_t),
    .axi_resp_t (rsp_t),
    .Resp       (RESP),
    .RespWidth  (64),
    .RespData   (DATA),
    .MaxTrans   (MT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (req),
    .slv_resp_o (rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_r(input logic [3:0] id, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) exp_r_q.push_back({id, i == int'(len)});
    rc++;
  endfunction

  // Negedge monitor: check outputs against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    logic exp_aw, exp_ar, exp_w, atop_hs;
    if (!rst_n) begin
      wq.delete();
      exp_b_q.delete();
      exp_r_q.delete();
      rc = 0;
      prev_r_stall = 1'b0;
      prev_b_stall = 1'b0;
    end else begin
      exp_aw  = (wq.size() < MT) && (!req.aw.atop[5] || rc < int'(MT));
      atop_hs = req.aw_valid && exp_aw && req.aw.atop[5];
      exp_ar  = (rc < int'(MT)) && !atop_hs;
      exp_w   = (wq.size() != 0) && (exp_b_q.size() < MT);
      chk("aw_ready", rsp.aw_ready, exp_aw);
      chk("ar_ready", rsp.ar_ready, exp_ar);
      chk("w_ready", rsp.w_ready, exp_w);
      chk("b_valid", rsp.b_valid, exp_b_q.size() != 0);
      if (rsp.b_valid && exp_b_q.size() != 0) begin
        chk("b_id", rsp.b.id, exp_b_q[0]);
        chk("b_resp", rsp.b.resp, RESP);
      end
      if (rc == 0) chk("r_valid_idle", rsp.r_valid, 1'b0);
      if (rsp.r_valid) begin
        chk("r_expected", exp_r_q.size() != 0, 1'b1);
        if (exp_r_q.size() != 0) begin
          chk("r_id", rsp.r.id, exp_r_q[0][4:1]);
          chk("r_last", rsp.r.last, exp_r_q[0][0]);
          chk("r_data", rsp.r.data, DATA);
          chk("r_resp", rsp.r.resp, RESP);
        end
      end
      if (prev_r_stall) chk("r_stable", {rsp.r_valid, rsp.r}, {1'b1, prev_r});
      if (prev_b_stall) chk("b_stable", {rsp.b_valid, rsp.b}, {1'b1, prev_b});
      prev_r_stall = rsp.r_valid && !req.r_ready;
      prev_b_stall = rsp.b_valid && !req.b_ready;
      prev_r = rsp.r;
      prev_b = rsp.b;
      if (rsp.b_valid && req.b_ready && exp_b_q.size() != 0) void'(exp_b_q.pop_front());
      if (req.w_valid && rsp.w_ready) begin
        chk("w_after_aw", wq.size() != 0, 1'b1);
        if (req.w.last && wq.size() != 0) exp_b_q.push_back(wq.pop_front());
      end
      if (req.aw_valid && rsp.aw_ready) begin
        wq.push_back(req.aw.id);
        if (req.aw.atop[5]) push_r(req.aw.id, req.aw.len);
      end
      if (req.ar_valid && rsp.ar_ready) push_r(req.ar.id, req.ar.len);
      if (rsp.r_valid && req.r_ready && exp_r_q.size() != 0) begin
        if (exp_r_q[0][0]) rc--;
        void'(exp_r_q.pop_front());
      end
    end
  end

  // Every driver task starts and ends 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [5:0] atop);
    logic ok;
    ok = 1'b0;
    req.aw.id = id; req.aw.len = len; req.aw.atop = atop; req.aw_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1 ok = rsp.aw_ready;
      cyc();
    end
    req.aw_valid = 1'b0;
    req.aw.atop = '0;
    chk("aw_accept", ok, 1'b1);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [7:0] len);
    logic ok;
    ok = 1'b0;
    req.ar.id = id; req.ar.len = len; req.ar_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1 ok = rsp.ar_ready;
      cyc();
    end
    req.ar_valid = 1'b0;
    chk("ar_accept", ok, 1'b1);
  endtask

  task automatic send_w(input logic last);
    logic ok;
    ok = 1'b0;
    req.w.last = last; req.w_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1 ok = rsp.w_ready;
      cyc();
    end
    req.w_valid = 1'b0;
    chk("w_accept", ok, 1'b1);
  endtask

  task automatic recv_r(input int n, input bit toggle, output int beats, output int lasts);
    beats = 0;
    lasts = 0;
    for (int i = 0; i < 2000 && beats < n; i++) begin
      req.r_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rsp.r_valid && req.r_ready) begin
        beats++;
        if (rsp.r.last) lasts++;
      end
      cyc();
    end
    req.r_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int beats, lasts;
    req = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aw_ready", rsp.aw_ready, 1'b1);
    chk("rst_ar_ready", rsp.ar_ready, 1'b1);
    chk("rst_w_ready", rsp.w_ready, 1'b0);
    chk("rst_b_valid", rsp.b_valid, 1'b0);
    chk("rst_r_valid", rsp.r_valid, 1'b0);
    chk("rst_payload", {rsp.b, rsp.r}, '0);
    rst_n = 1'b1;
    cyc();

    // Single write: W waits for its AW, B follows one cycle after W.last.
    req.b_ready = 1'b1;
    req.w.last = 1'b1;
    req.w_valid = 1'b1;
    cyc();
    #1 chk("w_ready_before_aw", rsp.w_ready, 1'b0);
    cyc();
    send_aw(4'd3, 8'd0, 6'd0);
    #1 chk("w_ready_after_aw", rsp.w_ready, 1'b1);
    cyc();
    req.w_valid = 1'b0;
    #1;
    chk("b_latency", rsp.b_valid, 1'b1);
    chk("b_single_id", rsp.b.id, 4'd3);
    chk("b_single_resp", rsp.b.resp, RESP);
    cyc();
    #1 chk("b_popped", rsp.b_valid, 1'b0);
    cyc();

    // Read burst of 4 beats with one bubble cycle before the first.
    req.r_ready = 1'b1;
    send_ar(4'd5, 8'd3);
    #1 chk("r_bubble", rsp.r_valid, 1'b0);
    cyc();
    recv_r(4, 1'b0, beats, lasts);
    chk("r4_beats", beats, 4);
    chk("r4_lasts", lasts, 1);

    // Backpressure: B FIFO and write-id FIFO both fill.
    req.b_ready = 1'b0;
    send_aw(4'd1, 8'd0, 6'd0); send_w(1'b1);
    send_aw(4'd2, 8'd0, 6'd0); send_w(1'b1);
    send_aw(4'd4, 8'd0, 6'd0);
    send_aw(4'd6, 8'd0, 6'd0);
    req.aw.id = 4'd8;
    req.aw_valid = 1'b1;
    req.w.last = 1'b1;
    req.w_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("aw_stall", rsp.aw_ready, 1'b0);
      chk("w_stall", rsp.w_ready, 1'b0);
      cyc();
    end
    req.aw_valid = 1'b0;
    req.w_valid = 1'b0;
    req.b_ready = 1'b1;
    send_w(1'b1);
    send_aw(4'd8, 8'd0, 6'd0);
    send_w(1'b1);
    send_w(1'b1);
    repeat (6) cyc();

    // ATOP with read response collides with an AR: the ATOP wins.
    req.aw.id = 4'd7; req.aw.len = 8'd1; req.aw.atop = 6'b100000; req.aw_valid = 1'b1;
    req.ar.id = 4'd9; req.ar.len = 8'd0; req.ar_valid = 1'b1;
    #1;
    chk("atop_ar_blocked", rsp.ar_ready, 1'b0);
    chk("atop_aw_ready", rsp.aw_ready, 1'b1);
    cyc();
    req.aw_valid = 1'b0;
    req.aw.atop = '0;
    #1 chk("ar_after_atop", rsp.ar_ready, 1'b1);
    cyc();
    req.ar_valid = 1'b0;
    recv_r(3, 1'b0, beats, lasts);
    chk("atop_r_beats", beats, 3);
    chk("atop_r_lasts", lasts, 2);
    send_w(1'b0);
    send_w(1'b1);
    repeat (4) cyc();

    // Longest burst under random r_ready.
    send_ar(4'd2, 8'd255);
    recv_r(256, 1'b1, beats, lasts);
    chk("r256_beats", beats, 256);
    chk("r256_lasts", lasts, 1);
    repeat (3) begin
      #1 chk("r_no_underflow", rsp.r_valid, 1'b0);
      cyc();
    end

    // Random traffic on all channels.
    for (int c = 0; c < 800; c++) begin
      req.aw_valid = ($urandom_range(0, 2) == 0);
      req.aw.id    = 4'($urandom);
      req.aw.len   = 8'($urandom_range(0, 3));
      req.aw.atop  = ($urandom_range(0, 3) == 0) ? 6'b100000 : 6'($urandom_range(0, 31));
      req.ar_valid = ($urandom_range(0, 2) == 0);
      req.ar.id    = 4'($urandom);
      req.ar.len   = 8'($urandom_range(0, 3));
      req.w_valid  = 1'($urandom_range(0, 1));
      req.w.last   = 1'($urandom_range(0, 1));
      req.b_ready  = 1'($urandom_range(0, 1));
      req.r_ready  = 1'($urandom_range(0, 1));
      cyc();
    end
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    req.aw.atop = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;
    req.w.last = 1'b1;
    for (int i = 0; i < 1000 && (wq.size() + exp_b_q.size() + exp_r_q.size()) != 0; i++) begin
      req.w_valid = (wq.size() != 0);
      cyc();
    end
    req.w_valid = 1'b0;
    chk("drained", wq.size() + exp_b_q.size() + exp_r_q.size(), 0);

    // Reset in the middle of an R burst with two Bs pending.
    req.b_ready = 1'b0;
    req.r_ready = 1'b0;
    send_ar(4'd1, 8'd7);
    send_aw(4'd2, 8'd0, 6'd0); send_w(1'b1);
    send_aw(4'd3, 8'd0, 6'd0); send_w(1'b1);
    cyc();
    #1;
    chk("pre_rst_r_valid", rsp.r_valid, 1'b1);
    chk("pre_rst_b_valid", rsp.b_valid, 1'b1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_r_valid", rsp.r_valid, 1'b0);
    chk("mid_rst_b_valid", rsp.b_valid, 1'b0);
    chk("mid_rst_aw_ready", rsp.aw_ready, 1'b1);
    chk("mid_rst_ar_ready", rsp.ar_ready, 1'b1);
    chk("mid_rst_w_ready", rsp.w_ready, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    chk("post_rst_r_valid", rsp.r_valid, 1'b0);
    chk("post_rst_b_valid", rsp.b_valid, 1'b0);
    cyc();
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;
    send_aw(4'd5, 8'd0, 6'd0);
    send_w(1'b1);
    send_ar(4'd6, 8'd1);
    repeat (6) cyc();
    chk("post_rst_drained", wq.size() + exp_b_q.size() + exp_r_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
